// File: rtl/sar_a2d_cntrl.sv
// Successive-approximation A2D controller: MSB-first binary search driving a ladder DAC.
// Optional macro SAR_AVG_EN averages four back-to-back conversions per start.
module sar_a2d_cntrl #(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned SETTLE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strt,
    input  logic             cmp,
    output logic [WIDTH-1:0] dac,
    output logic [WIDTH-1:0] result,
    output logic             cmplt,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(SETTLE);
    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MSB_CODE = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRIAL = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_nxt;
    logic [WIDTH-1:0] dac_q, dac_nxt;
    logic [WIDTH-1:0] result_q, result_nxt;
    logic             cmplt_q, cmplt_nxt;
    logic             busy_q, busy_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [IDX_W-1:0] idx_q, idx_nxt;
    logic [WIDTH-1:0] code;
`ifdef SAR_AVG_EN
    logic [WIDTH+1:0] acc_q, acc_nxt, acc_sum;
    logic [1:0]       conv_q, conv_nxt;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            dac_q    <= '0;
            result_q <= '0;
            cmplt_q  <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
`ifdef SAR_AVG_EN
            acc_q    <= '0;
            conv_q   <= '0;
`endif
        end else begin
            state_q  <= state_nxt;
            dac_q    <= dac_nxt;
            result_q <= result_nxt;
            cmplt_q  <= cmplt_nxt;
            busy_q   <= busy_nxt;
            cnt_q    <= cnt_nxt;
            idx_q    <= idx_nxt;
`ifdef SAR_AVG_EN
            acc_q    <= acc_nxt;
            conv_q   <= conv_nxt;
`endif
        end
    end

    // Next-state, trial-code and registered-output logic
    always_comb begin
        state_nxt  = state_q;
        dac_nxt    = dac_q;
        result_nxt = result_q;
        cmplt_nxt  = 1'b0;
        busy_nxt   = 1'b0;
        cnt_nxt    = cnt_q;
        idx_nxt    = idx_q;
        code       = dac_q;
`ifdef SAR_AVG_EN
        acc_nxt    = acc_q;
        conv_nxt   = conv_q;
        acc_sum    = acc_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (strt) begin
                    state_nxt = TRIAL;
                    dac_nxt   = MSB_CODE;
                    idx_nxt   = IDX_MSB;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
`ifdef SAR_AVG_EN
                    acc_nxt   = '0;
                    conv_nxt  = '0;
`endif
                end
            end

            TRIAL: begin
                busy_nxt = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    if (!cmp) begin
                        code[idx_q] = 1'b0;
                    end
                    cnt_nxt = '0;
                    if (idx_q != '0) begin
                        dac_nxt = code | (WIDTH'(1) << (idx_q - IDX_W'(1)));
                        idx_nxt = idx_q - IDX_W'(1);
                    end else begin
`ifdef SAR_AVG_EN
                        acc_sum = acc_q + (WIDTH+2)'(code);
                        acc_nxt = acc_sum;
                        if (conv_q == 2'd3) begin
                            state_nxt  = DONE;
                            dac_nxt    = code;
                            result_nxt = acc_sum[WIDTH+1:2];
                            cmplt_nxt  = 1'b1;
                            busy_nxt   = 1'b0;
                        end else begin
                            // Next sub-conversion starts on the very next edge
                            conv_nxt = conv_q + 2'd1;
                            dac_nxt  = MSB_CODE;
                            idx_nxt  = IDX_MSB;
                        end
`else
                        state_nxt  = DONE;
                        dac_nxt    = code;
                        result_nxt = code;
                        cmplt_nxt  = 1'b1;
                        busy_nxt   = 1'b0;
`endif
                    end
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign dac    = dac_q;
    assign result = result_q;
    assign cmplt  = cmplt_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_sar_a2d_cntrl.sv
// Scoreboard bench for sar_a2d_cntrl: default instance plus a WIDTH=4/SETTLE=2 instance.
module tb_sar_a2d_cntrl;

`ifdef SAR_AVG_EN
    localparam int CONV = 4;
`else
    localparam int CONV = 1;
`endif
    localparam int LAT   = CONV * 10 * 4 + 1;
    localparam int LAT_S = CONV * 4 * 2 + 1;

    typedef struct {
        int res;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       strt, strt_s;
    logic [9:0] vin;
    logic [3:0] vin_s;
    logic       cmp, cmp_s;
    logic [9:0] dac, result;
    logic [3:0] dac_s, result_s;
    logic       cmplt, busy, cmplt_s, busy_s;

    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t q_main[$];
    exp_t q_small[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign cmp   = (vin >= dac);
    assign cmp_s = (vin_s >= dac_s);

    sar_a2d_cntrl u_dut (
        .clk(clk), .rst(rst), .strt(strt), .cmp(cmp),
        .dac(dac), .result(result), .cmplt(cmplt), .busy(busy)
    );

    sar_a2d_cntrl #(.WIDTH(4), .SETTLE(2)) u_small (
        .clk(clk), .rst(rst), .strt(strt_s), .cmp(cmp_s),
        .dac(dac_s), .result(result_s), .cmplt(cmplt_s), .busy(busy_s)
    );

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_main(input int res, input int c);
        exp_t e;
        e.res = res;
        e.cyc = c;
        q_main.push_back(e);
    endtask

    // Monitors: pop one expectation per completion pulse
    always @(negedge clk) begin
        exp_t e;
        if (cmplt === 1'b1) begin
            if (q_main.size() == 0) begin
                check("main_unexpected_cmplt", 1, 0);
            end else begin
                e = q_main.pop_front();
                check("main_result", int'(result), e.res);
                check("main_cmplt_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (cmplt_s === 1'b1) begin
            if (q_small.size() == 0) begin
                check("small_unexpected_cmplt", 1, 0);
            end else begin
                e = q_small.pop_front();
                check("small_result", int'(result_s), e.res);
                check("small_cmplt_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int   t0;
        int   t1;
        exp_t es;

        rst = 1'b1; strt = 1'b0; strt_s = 1'b0; vin = '0; vin_s = '0;
        goto(3);
        rst = 1'b0;
        check("reset_dac", int'(dac), 0);
        check("reset_result", int'(result), 0);
        check("reset_cmplt", int'(cmplt), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_dac_small", int'(dac_s), 0);
        goto(cyc + 1);

        // Binary search on 0x2A5, small instance on 0x9 in parallel
        vin = 10'h2A5; vin_s = 4'h9;
        t0 = cyc;
        strt = 1'b1; strt_s = 1'b1;
        push_main(32'h2A5, t0 + LAT);
        es.res = 9; es.cyc = t0 + LAT_S;
        q_small.push_back(es);
        goto(t0 + 1);
        strt = 1'b0; strt_s = 1'b0;
        check("dac_trial0", int'(dac), 32'h200);
        check("busy_first", int'(busy), 1);
        goto(t0 + 5);  check("dac_trial1", int'(dac), 32'h300);
        goto(t0 + 9);  check("dac_trial2", int'(dac), 32'h280);
        goto(t0 + 13); check("dac_trial3", int'(dac), 32'h2C0);
        goto(t0 + LAT - 1); check("busy_last", int'(busy), 1);
        goto(t0 + LAT);
        check("busy_done", int'(busy), 0);
        check("dac_final", int'(dac), 32'h2A5);
        goto(t0 + LAT + 2);

        // Extremes: all-zero then full-scale input
        vin = 10'h000;
        t0 = cyc;
        strt = 1'b1;
        push_main(0, t0 + LAT);
        goto(t0 + 1); strt = 1'b0;
        goto(t0 + LAT + 1);
        vin = 10'h3FF;
        t1 = cyc;
        strt = 1'b1;
        push_main(32'h3FF, t1 + LAT);
        goto(t1 + 1); strt = 1'b0;
        goto(t1 + LAT + 2);

        // strt held high: back-to-back conversions
        vin = 10'h155;
        t0 = cyc;
        strt = 1'b1;
        push_main(32'h155, t0 + LAT);
        push_main(32'h155, t0 + 2 * LAT);
        push_main(32'h155, t0 + 3 * LAT);
        goto(t0 + LAT);         check("b2b_busy_drop1", int'(busy), 0);
        goto(t0 + LAT + 1);     check("b2b_busy_rise", int'(busy), 1);
        goto(t0 + 2 * LAT);     check("b2b_busy_drop2", int'(busy), 0);
        goto(t0 + 2 * LAT + 5); strt = 1'b0;
        goto(t0 + 3 * LAT + 1); check("b2b_stopped", int'(busy), 0);
        goto(t0 + 3 * LAT + 2);

        // strt pulses during TRIAL are ignored
        vin = 10'h0F0;
        t0 = cyc;
        strt = 1'b1;
        push_main(32'h0F0, t0 + LAT);
        goto(t0 + 1);  strt = 1'b0;
        goto(t0 + 10); strt = 1'b1;
        goto(t0 + 11); strt = 1'b0;
        goto(t0 + 30); strt = 1'b1;
        goto(t0 + 31); strt = 1'b0;
        goto(t0 + LAT + 3);
        check("ignored_strt_idle", int'(busy), 0);

        // Reset mid-conversion discards it
        vin = 10'h1C3;
        t0 = cyc;
        strt = 1'b1;
        goto(t0 + 1);  strt = 1'b0;
        goto(t0 + 20); rst = 1'b1;
        goto(t0 + 21); rst = 1'b0;
        check("midrst_dac", int'(dac), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_result", int'(result), 0);
        goto(t0 + LAT + 10);
        t1 = cyc;
        strt = 1'b1;
        push_main(32'h1C3, t1 + LAT);
        goto(t1 + 1); strt = 1'b0;
        goto(t1 + LAT + 2);

`ifdef SAR_AVG_EN
        // Averaging: input stepped per sub-conversion
        vin = 10'h100;
        t0 = cyc;
        strt = 1'b1;
        push_main(32'h101, t0 + LAT);
        goto(t0 + 1);  strt = 1'b0;
        goto(t0 + 41);  vin = 10'h101;
        goto(t0 + 81);  vin = 10'h102;
        goto(t0 + 121); vin = 10'h103;
        goto(t0 + LAT + 2);
`endif

        t0 = cyc;
        while ((q_main.size() != 0 || q_small.size() != 0) && cyc < t0 + 400) begin
            @(posedge clk); #1;
        end
        check("sb_main_drained", q_main.size(), 0);
        check("sb_small_drained", q_small.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
